// File: rtl/bus_select_pkg.sv
// Shared definitions for the bus chip-select controller: FSM states,
// the default memory map (RAM / IO / ROM) and the region index width helper.
package bus_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  // Default map: region 0 RAM (fallback), region 1 IO, region 2 ROM
  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] RAM_MASK = 16'h0000;
  localparam logic [2:0]  RAM_WS   = 3'd0;
  localparam logic [15:0] IO_BASE  = 16'hD000;
  localparam logic [15:0] IO_MASK  = 16'hF000;
  localparam logic [2:0]  IO_WS    = 3'd2;
  localparam logic [15:0] ROM_BASE = 16'hE000;
  localparam logic [15:0] ROM_MASK = 16'hE000;
  localparam logic [2:0]  ROM_WS   = 3'd1;

  // Bits needed to hold a region index; never narrower than one bit
  function automatic int region_idx_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/bus_select_ctrl_if.sv
// Bus-side bundle of the chip-select controller. The master drives the
// request, the controller (slave) returns selects, handshake and status.
interface bus_select_ctrl_if #(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 3
);
  logic [ADDR_W-1:0]      address;
  logic                   req;
  logic [NUM_REGIONS-1:0] cs_n;
  logic                   ready;
  logic                   decode_err;
  logic                   busy;
  logic [ADDR_W-1:0]      latched_addr;

  modport master (
    output address, req,
    input  cs_n, ready, decode_err, busy, latched_addr
  );

  modport slave (
    input  address, req,
    output cs_n, ready, decode_err, busy, latched_addr
  );
endinterface

// File: rtl/bus_select_ctrl_region_match.sv
// Combinational address decoder: per-region masked compare, highest index
// wins, and the default region is used only when nothing else matches.
module region_match
  import bus_select_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 3,
  parameter int IDX_W       = region_idx_w(NUM_REGIONS),
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {ROM_BASE, IO_BASE, RAM_BASE},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {ROM_MASK, IO_MASK, RAM_MASK},
  parameter int DEFAULT_REGION = 0
) (
  input  logic [ADDR_W-1:0] address,
  output logic              hit,
  output logic [IDX_W-1:0]  index
);

  localparam bit HAS_FALLBACK = (DEFAULT_REGION < NUM_REGIONS);

  logic [NUM_REGIONS-1:0] match_s;
  logic                   any_s;

  // Masked compare of every region except the fallback one
  always_comb begin
    match_s = {NUM_REGIONS{1'b0}};
    for (int i = 0; i < NUM_REGIONS; i++) begin
      match_s[i] = (i != DEFAULT_REGION) &&
                   ((address & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                    (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W]));
    end
  end

  // Ascending scan so the highest matching index overrides lower ones
  always_comb begin
    index = IDX_W'(0);
    for (int i = 0; i < NUM_REGIONS; i++) begin
      index = match_s[i] ? IDX_W'(i) : index;
    end
    any_s = |match_s;
    index = (!any_s && HAS_FALLBACK) ? IDX_W'(DEFAULT_REGION) : index;
    hit   = any_s || HAS_FALLBACK;
  end

endmodule

// File: rtl/bus_select_ctrl.sv
// Bus chip-select controller: decodes the request address into one of
// NUM_REGIONS active-low selects, inserts per-region wait states and
// returns a one-cycle ready (or decode_err for unmapped accesses).
module bus_select_ctrl
  import bus_select_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 3,
  parameter int WS_W        = 3,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {ROM_BASE, IO_BASE, RAM_BASE},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {ROM_MASK, IO_MASK, RAM_MASK},
  parameter logic [NUM_REGIONS*WS_W-1:0]   REGION_WS   = {ROM_WS, IO_WS, RAM_WS},
  parameter int DEFAULT_REGION = 0
) (
  input logic             clk,
  input logic             reset,
  bus_select_ctrl_if.slave bus
);

  localparam int IDX_W = region_idx_w(NUM_REGIONS);

  state_e                 state_r, state_s;
  logic [WS_W-1:0]        cnt_r, ws_s;
  logic [ADDR_W-1:0]      addr_r;
  logic [IDX_W-1:0]       region_r, region_s, idx_s;
  logic [NUM_REGIONS-1:0] sel_s, cs_n_r;
  logic                   hit_s, accept_s, release_r;
  logic                   ready_r, decode_err_r, busy_r;

  region_match #(
    .ADDR_W         (ADDR_W),
    .NUM_REGIONS    (NUM_REGIONS),
    .IDX_W          (IDX_W),
    .REGION_BASE    (REGION_BASE),
    .REGION_MASK    (REGION_MASK),
    .DEFAULT_REGION (DEFAULT_REGION)
  ) u_match (
    .address (bus.address),
    .hit     (hit_s),
    .index   (idx_s)
  );

  // A new cycle starts only after req has been seen low since the last one
  assign accept_s = (state_r == ST_IDLE) && bus.req && !release_r;

  // Region currently owning the bus: freshly decoded on acceptance, else held
  always_comb begin
    region_s = (accept_s && hit_s) ? idx_s : region_r;
  end

  // Wait-state lookup for the decoded region and one-hot of the owning region
  always_comb begin
    ws_s  = WS_W'(0);
    sel_s = {NUM_REGIONS{1'b0}};
    for (int i = 0; i < NUM_REGIONS; i++) begin
      ws_s     = (idx_s == IDX_W'(i)) ? REGION_WS[i*WS_W +: WS_W] : ws_s;
      sel_s[i] = (region_s == IDX_W'(i));
    end
  end

  // Next-state logic; a dropped req in ACCESS aborts straight to IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = hit_s ? ST_ACCESS : ST_ERR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!bus.req) begin
          state_s = ST_IDLE;
        end else if (cnt_r == WS_W'(0)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs follow the next state; counter, latch and release flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r        <= WS_W'(0);
      addr_r       <= ADDR_W'(0);
      region_r     <= IDX_W'(0);
      release_r    <= 1'b1;
      cs_n_r       <= {NUM_REGIONS{1'b1}};
      ready_r      <= 1'b0;
      decode_err_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      region_r     <= region_s;
      cs_n_r       <= ((state_s == ST_ACCESS) || (state_s == ST_DONE)) ?
                      ~sel_s : {NUM_REGIONS{1'b1}};
      ready_r      <= (state_s == ST_DONE);
      decode_err_r <= (state_s == ST_ERR);
      busy_r       <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s && hit_s) begin
            addr_r <= bus.address;
            cnt_r  <= ws_s;
          end else begin
            cnt_r  <= WS_W'(0);
          end
          release_r <= release_r && bus.req;
        end
        ST_ACCESS: begin
          if (bus.req && (cnt_r != WS_W'(0))) begin
            cnt_r <= cnt_r - WS_W'(1);
          end else begin
            cnt_r <= WS_W'(0);
          end
        end
        ST_DONE, ST_ERR: begin
          cnt_r     <= WS_W'(0);
          release_r <= 1'b1;
        end
        default: cnt_r <= WS_W'(0);
      endcase
    end
  end

  assign bus.cs_n         = cs_n_r;
  assign bus.ready        = ready_r;
  assign bus.decode_err   = decode_err_r;
  assign bus.busy         = busy_r;
  assign bus.latched_addr = addr_r;

endmodule

// File: tb/tb_bus_select_ctrl.sv
// Self-checking bench for bus_select_ctrl: a directed vector table, a few
// hand-written reset/release sequences and randomized transactions checked
// against a transaction-level timeline model. Two instances are used: the
// default map, and one without a fallback region (region 0 narrowed to
// addresses with bit 14 set so that unmapped holes exist).
module tb_bus_select_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_select_ctrl_if #(.ADDR_W(16), .NUM_REGIONS(3)) bf ();
  bus_select_ctrl_if #(.ADDR_W(16), .NUM_REGIONS(3)) bn ();

  bus_select_ctrl dut_f (
    .clk   (clk),
    .reset (reset),
    .bus   (bf)
  );

  bus_select_ctrl #(
    .REGION_BASE    ({16'hE000, 16'hD000, 16'h4000}),
    .REGION_MASK    ({16'hE000, 16'hF000, 16'h4000}),
    .DEFAULT_REGION (3)
  ) dut_n (
    .clk   (clk),
    .reset (reset),
    .bus   (bn)
  );

  typedef struct {
    int          sel;
    logic [15:0] addr;
    int          region;
    int          ws;
    int          abort_at;
    int          hold;
    int          chg;
    logic [15:0] chg_addr;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_lat [2];
  vec_t        vecs [17];

  task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cs_n,ready,err,busy,latched)", name, got, exp);
    end
  endtask

  function automatic logic [21:0] obs(input int sel);
    if (sel == 1) return {bn.cs_n, bn.ready, bn.decode_err, bn.busy, bn.latched_addr};
    else          return {bf.cs_n, bf.ready, bf.decode_err, bf.busy, bf.latched_addr};
  endfunction

  task automatic set_req(input int sel, input logic v);
    if (sel == 1) bn.req = v; else bf.req = v;
  endtask

  task automatic set_addr(input int sel, input logic [15:0] a);
    if (sel == 1) bn.address = a; else bf.address = a;
  endtask

  // Reference decode: scan regions from the highest index, skip the fallback
  function automatic int model_region(input int sel, input logic [15:0] a);
    logic [15:0] base [3];
    logic [15:0] mask [3];
    int dflt;
    base[1] = 16'hD000; mask[1] = 16'hF000;
    base[2] = 16'hE000; mask[2] = 16'hE000;
    if (sel == 1) begin
      base[0] = 16'h4000; mask[0] = 16'h4000; dflt = 3;
    end else begin
      base[0] = 16'h0000; mask[0] = 16'h0000; dflt = 0;
    end
    for (int i = 2; i >= 0; i--) begin
      if (i != dflt && ((a & mask[i]) == (base[i] & mask[i]))) return i;
    end
    return (dflt < 3) ? dflt : -1;
  endfunction

  function automatic int model_ws(input int r);
    case (r)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  // One bus cycle: raise req, then check every cycle against the timeline
  // (r < 0 means an unmapped access, a > 0 drops req in cycle a,
  // hold keeps req high for extra cycles after completion)
  task automatic run_txn(input int sel, input logic [15:0] addr, input int r, input int w,
                         input int a, input int hold, input int chg,
                         input logic [15:0] chg_addr, input string tag);
    int last;
    logic [2:0] one, ecs;
    logic erdy, eerr, ebusy;
    @(negedge clk);
    set_addr(sel, addr);
    set_req(sel, 1'b1);
    last = (r < 0) ? 1 : ((a > 0) ? a : w + 2);
    for (int k = 1; k <= last + 1 + hold; k++) begin
      @(negedge clk);
      one = 3'b001; ecs = 3'b111; erdy = 1'b0; eerr = 1'b0; ebusy = 1'b0;
      if (k == 1 && r >= 0) exp_lat[sel] = addr;
      if (k <= last) begin
        ebusy = 1'b1;
        if (r < 0) begin
          eerr = 1'b1;
        end else begin
          ecs  = ~(one << r);
          erdy = (a == 0) && (k == w + 2);
        end
      end
      check($sformatf("%s cyc%0d", tag, k), obs(sel), {ecs, erdy, eerr, ebusy, exp_lat[sel]});
      if (chg == 1 && k == 1) set_addr(sel, chg_addr);
      else if (chg == 2) set_addr(sel, 16'($urandom));
      if (k == last + hold) set_req(sel, 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, w, a, h, c;
    logic [15:0] ad;

    //            sel addr      reg ws ab hold chg new
    vecs[0]  = '{0, 16'hD123,  1, 2, 0, 0, 0, 16'h0000};
    vecs[1]  = '{0, 16'hF000,  2, 1, 0, 0, 0, 16'h0000};
    vecs[2]  = '{0, 16'h9000,  0, 0, 0, 0, 0, 16'h0000};
    vecs[3]  = '{1, 16'h9000, -1, 0, 0, 0, 0, 16'h0000};
    vecs[4]  = '{0, 16'hD000,  1, 2, 2, 0, 0, 16'h0000};
    vecs[5]  = '{0, 16'hD000,  1, 2, 0, 0, 1, 16'hE000};
    vecs[6]  = '{0, 16'hFFFF,  2, 1, 0, 3, 0, 16'h0000};
    vecs[7]  = '{1, 16'h9000, -1, 0, 0, 2, 0, 16'h0000};
    vecs[8]  = '{1, 16'hD000,  1, 2, 0, 0, 0, 16'h0000};
    vecs[9]  = '{1, 16'hF000,  2, 1, 0, 0, 0, 16'h0000};
    vecs[10] = '{1, 16'h4000,  0, 0, 0, 0, 0, 16'h0000};
    vecs[11] = '{1, 16'h0000, -1, 0, 0, 0, 0, 16'h0000};
    vecs[12] = '{0, 16'hCFFF,  0, 0, 0, 0, 0, 16'h0000};
    vecs[13] = '{0, 16'hDFFF,  1, 2, 0, 0, 0, 16'h0000};
    vecs[14] = '{0, 16'hE000,  2, 1, 0, 0, 0, 16'h0000};
    vecs[15] = '{0, 16'hD000,  1, 2, 1, 0, 0, 16'h0000};
    vecs[16] = '{0, 16'hF000,  2, 1, 2, 0, 0, 16'h0000};

    reset = 1'b1;
    bf.req = 1'b0; bf.address = 16'h0000;
    bn.req = 1'b0; bn.address = 16'h0000;
    exp_lat[0] = 16'h0000; exp_lat[1] = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_f", obs(0), {3'b111, 1'b0, 1'b0, 1'b0, 16'h0000});
    check("reset_n", obs(1), {3'b111, 1'b0, 1'b0, 1'b0, 16'h0000});
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_txn(vecs[i].sel, vecs[i].addr, vecs[i].region, vecs[i].ws, vecs[i].abort_at,
              vecs[i].hold, vecs[i].chg, vecs[i].chg_addr, $sformatf("vec%0d", i));
    end

    // Reset in the middle of an IO access, with req still held afterwards
    @(negedge clk);
    set_addr(0, 16'hD000);
    set_req(0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    exp_lat[0] = 16'hD000;
    check("pre_rst_access", obs(0), {3'b101, 1'b0, 1'b0, 1'b1, 16'hD000});
    reset = 1'b1;
    @(negedge clk);
    exp_lat[0] = 16'h0000; exp_lat[1] = 16'h0000;
    check("rst_mid_access", obs(0), {3'b111, 1'b0, 1'b0, 1'b0, 16'h0000});
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_held_1", obs(0), {3'b111, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    check("rst_req_held_2", obs(0), {3'b111, 1'b0, 1'b0, 1'b0, 16'h0000});
    set_req(0, 1'b0);
    run_txn(0, 16'hD000, 1, 2, 0, 0, 0, 16'h0000, "post_rst");

    // Randomized transactions against the timeline model
    for (int i = 0; i < 60; i++) begin
      int s;
      s  = int'($urandom_range(0, 1));
      ad = 16'($urandom);
      r  = model_region(s, ad);
      w  = (r >= 0) ? model_ws(r) : 0;
      a  = 0;
      if (r >= 0 && $urandom_range(0, 3) == 0) a = int'($urandom_range(1, w + 1));
      h  = (a == 0) ? int'($urandom_range(0, 2)) : 0;
      c  = int'($urandom_range(0, 2));
      run_txn(s, ad, r, w, a, h, c, 16'($urandom), $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_select_ctrl.md
BUS_SELECT_CTRL -- requirements
Module: bus_select_ctrl

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 16, as the bus address width.
REQ-002 The block SHALL take parameter NUM_REGIONS, default 3, as the number of decoded regions and chip selects.
REQ-003 The block SHALL take parameter WS_W, default 3, as the wait-state count width.
REQ-004 The block SHALL take parameter REGION_BASE, default {16'hE000, 16'hD000, 16'h0000}, as the per-region base address, packed NUM_REGIONS x ADDR_W.
REQ-005 The block SHALL take parameter REGION_MASK, default {16'hE000, 16'hF000, 16'h0000}, as the per-region compare mask, packed NUM_REGIONS x ADDR_W.
REQ-006 The block SHALL take parameter REGION_WS, default {3'd1, 3'd2, 3'd0}, as the per-region wait states, packed NUM_REGIONS x WS_W.
REQ-007 The block SHALL take parameter DEFAULT_REGION, default 0, as the region selected when no other region matches; a value of NUM_REGIONS disables the fallback.
REQ-008 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-009 Port reset: input, 1 bit, synchronous active-high reset.
REQ-010 Port address: input, ADDR_W bits, bus address, sampled with req.
REQ-011 Port req: input, 1 bit, bus cycle request, held high until ready or abort.
REQ-012 Port cs_n: output, NUM_REGIONS bits, active-low one-cold chip selects.
REQ-013 Port ready: output, 1 bit, one-cycle cycle-complete pulse.
REQ-014 Port decode_err: output, 1 bit, one-cycle pulse for an unmapped access.
REQ-015 Port busy: output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-016 Region i SHALL match when (address & MASK[i]) == (BASE[i] & MASK[i]); the default region SHALL be excluded from matching.
REQ-017 When multiple regions match, the highest index SHALL win.
REQ-018 The FSM SHALL have states IDLE, ACCESS, DONE and ERR.
REQ-019 In IDLE with req=1 and a match, the block SHALL latch address and region, load the wait counter with that region's WS, assert that region's cs_n low on the next cycle, and enter ACCESS.
REQ-020 In IDLE with req=1 and no match and the fallback disabled, the block SHALL enter ERR, pulse decode_err for exactly one cycle, and assert no cs_n.
REQ-021 In ACCESS the counter SHALL decrement each cycle; when it is 0, the block SHALL enter DONE.
REQ-022 In DONE, ready SHALL be high for one cycle with cs_n still asserted, and the block SHALL return to IDLE; cs_n SHALL deassert on the following cycle.
REQ-023 Latency from req sampled to ready SHALL be WS+2 cycles; WS=0 gives ready on the second cycle.
REQ-024 If req drops in ACCESS, the block SHALL abort to IDLE on the next edge: cs_n all high, no ready pulse.
REQ-025 From ERR the block SHALL return to IDLE and SHALL NOT accept a new req until req has been low for at least one cycle; the same rule SHALL apply after DONE.
REQ-026 Address changes after latching SHALL NOT alter the selected region or the wait count.
REQ-027 At most one cs_n bit SHALL be low at any time; ready and decode_err SHALL never be high together.

Reset
REQ-028 Reset SHALL force state IDLE, cs_n to all ones, ready=0, decode_err=0, busy=0, counter=0, and clear the latched address; this SHALL take effect within one edge, including mid-access.

Structure
REQ-029 Package bus_select_pkg SHALL hold the FSM state enum, the default map constants (RAM/IO/ROM base, mask and WS), and the region index width function.
REQ-030 A combinational sub-module region_match SHALL perform the per-region compare and the priority encode, outputting hit and index.

Verification
REQ-031 Read 0xD123 with default parameters -> cs_n=3'b101 one cycle after req, ready at cycle 4, cs_n all high at cycle 5.
REQ-032 Read 0xF000 -> cs_n=3'b011, ready at cycle 3; read 0x9000 -> fallback cs_n=3'b110, ready at cycle 2.
REQ-033 With DEFAULT_REGION=3, read 0x9000 -> decode_err pulse for one cycle, cs_n stays 3'b111, no ready.
REQ-034 Drop req in the cycle after cs_n asserts on 0xD000 -> cs_n returns to 3'b111, no ready pulse, busy low.
REQ-035 Assert reset during ACCESS on 0xD000 -> all outputs at reset values after one edge; a new request is accepted after req has been low for one cycle.
REQ-036 Change address from 0xD000 to 0xE000 after latching -> cs_n stays 3'b101 with a 2-wait-state timing.
